// File: rtl/seq_mux_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : seq_mux_pipe
//  Purpose  : CHANNELS-way input multiplexer feeding an operating register
//             (load / hold / add / xor), followed by DEPTH-1 stall-able delay
//             stages that carry data, valid and carry-out together.
//  Ports    : clk        - clock, all state changes on its rising edge
//             CLR        - asynchronous active-high reset of all state
//             D          - packed channels, channel i = D[(i+1)*WIDTH-1 -: WIDTH]
//             sel        - channel select
//             mode       - stage-0 op: 00 LOAD, 01 HOLD, 10 ADD, 11 XOR
//             in_valid   - sample qualifier for this cycle
//             en         - pipeline advance, 0 stalls every stage
//             sclr       - synchronous clear of every stage
//             out        - data of the last stage
//             out_valid  - valid of the last stage
//             ovf        - carry-out of the ADD that produced out
//  Revision : 1.0 - initial release
// ============================================================================
module seq_mux_pipe #(
    parameter  int WIDTH    = 5,
    parameter  int CHANNELS = 4,
    parameter  int DEPTH    = 2,
    localparam int SELW     = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      CLR,
    input  logic [CHANNELS*WIDTH-1:0] D,
    input  logic [SELW-1:0]           sel,
    input  logic [1:0]                mode,
    input  logic                      in_valid,
    input  logic                      en,
    input  logic                      sclr,
    output logic [WIDTH-1:0]          out,
    output logic                      out_valid,
    output logic                      ovf
);

    localparam logic [1:0] c_MODE_LOAD = 2'b00;
    localparam logic [1:0] c_MODE_HOLD = 2'b01;
    localparam logic [1:0] c_MODE_ADD  = 2'b10;
    localparam logic [1:0] c_MODE_XOR  = 2'b11;

    // Stage 0: operating register
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             v0_q,  v0_d;
    logic             c0_q,  c0_d;

    logic [WIDTH-1:0] w_x;
    logic [WIDTH:0]   w_sum;

    // Channel select written as a compare loop so no out-of-range part-select
    // can be formed from the select value.
    always_comb begin
        w_x = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel == SELW'(i)) begin
                w_x = D[i*WIDTH +: WIDTH];
            end
        end
    end

    // One extra bit so the ADD carry-out lands in the MSB.
    assign w_sum = {1'b0, acc_q} + {1'b0, w_x};

    always_comb begin
        acc_d = acc_q;
        v0_d  = v0_q;
        c0_d  = c0_q;
        if (sclr) begin
            acc_d = '0;
            v0_d  = 1'b0;
            c0_d  = 1'b0;
        end else if (en) begin
            if (in_valid) begin
                v0_d = 1'b1;
                c0_d = 1'b0;
                case (mode)
                    c_MODE_LOAD: acc_d = w_x;
                    c_MODE_HOLD: acc_d = acc_q;
                    c_MODE_ADD:  {c0_d, acc_d} = w_sum;
                    c_MODE_XOR:  acc_d = acc_q ^ w_x;
                    default:     acc_d = acc_q;
                endcase
            end else begin
                // Bubble: accumulator keeps its value, only the qualifiers drop.
                v0_d = 1'b0;
                c0_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            acc_q <= '0;
            v0_q  <= 1'b0;
            c0_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            v0_q  <= v0_d;
            c0_q  <= c0_d;
        end
    end

    // Delay stages 1..DEPTH-1
    if (DEPTH == 1) begin : g_direct
        assign out       = acc_q;
        assign out_valid = v0_q;
        assign ovf       = c0_q;
    end else begin : g_pipe
        logic [WIDTH-1:0] data_q [1:DEPTH-1];
        logic [DEPTH-1:1] valid_q;
        logic [DEPTH-1:1] carry_q;

        always_ff @(posedge clk or posedge CLR) begin
            if (CLR) begin
                for (int k = 1; k < DEPTH; k++) begin
                    data_q[k] <= '0;
                end
                valid_q <= '0;
                carry_q <= '0;
            end else if (sclr) begin
                for (int k = 1; k < DEPTH; k++) begin
                    data_q[k] <= '0;
                end
                valid_q <= '0;
                carry_q <= '0;
            end else if (en) begin
                data_q[1]  <= acc_q;
                valid_q[1] <= v0_q;
                carry_q[1] <= c0_q;
                for (int k = 2; k < DEPTH; k++) begin
                    data_q[k]  <= data_q[k-1];
                    valid_q[k] <= valid_q[k-1];
                    carry_q[k] <= carry_q[k-1];
                end
            end
        end

        assign out       = data_q[DEPTH-1];
        assign out_valid = valid_q[DEPTH-1];
        assign ovf       = carry_q[DEPTH-1];
    end

endmodule
`default_nettype wire
